onchip_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 32-bit on-chip memory (10240 words, 14-bit word address, byte enables, one-cycle read latency) between two Avalon-MM masters. It sits between the interconnect and the memory's s1 port, typically Nios II data master on port 0 and a DMA/LED-pattern engine on port 1. It issues at most one access per clock, stalls the loser with waitrequest, and returns read data with readdatavalid tagged to the issuing port.

---
 rtl/onchip_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single-port on-chip memory (one-cycle read latency).
// Define ONCHIP_ARB_HOLD_EN for MAX_HOLD-bounded ownership; otherwise contention strictly alternates.
module onchip_mem_arbiter #(
  parameter int AW       = 14,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            reset_n,

  input  logic [AW-1:0]   m0_address,
  input  logic [DW/8-1:0] m0_byteenable,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [DW-1:0]   m0_writedata,
  output logic            m0_waitrequest,
  output logic [DW-1:0]   m0_readdata,
  output logic            m0_readdatavalid,

  input  logic [AW-1:0]   m1_address,
  input  logic [DW/8-1:0] m1_byteenable,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [DW-1:0]   m1_writedata,
  output logic            m1_waitrequest,
  output logic [DW-1:0]   m1_readdata,
  output logic            m1_readdatavalid,

  output logic [AW-1:0]   mem_address,
  output logic [DW/8-1:0] mem_byteenable,
  output logic            mem_chipselect,
  output logic            mem_write,
  output logic [DW-1:0]   mem_writedata,
  input  logic [DW-1:0]   mem_readdata
);

  localparam int BW = DW / 8;

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_range
    $error("onchip_mem_arbiter: MAX_HOLD must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   req0, req1;
  logic   grant0, grant1, granted;
  logic   keep_owner;
  logic   new_owner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef ONCHIP_ARB_HOLD_EN
  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);
  logic [3:0] hold_q, hold_d;

  assign keep_owner = (hold_q < HOLD_LIMIT);
`else
  assign keep_owner = 1'b0;
`endif

  // Grants are forced off while reset is asserted so nothing reaches the memory.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      case (state_q)
        OWN0: begin
          if (req0 && (!req1 || keep_owner)) grant0 = 1'b1;
          else if (req1)                     grant1 = 1'b1;
        end
        OWN1: begin
          if (req1 && (!req0 || keep_owner)) grant1 = 1'b1;
          else if (req0)                     grant0 = 1'b1;
        end
        default: begin
          // From IDLE the port that did not win last time takes a contended slot.
          if (req0 && (!req1 || last_q)) grant0 = 1'b1;
          else if (req1)                 grant1 = 1'b1;
        end
      endcase
    end
  end

  assign granted   = grant0 | grant1;
  assign new_owner = granted & ((state_q == IDLE) | (grant1 != last_q));

  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    if (grant0) begin
      state_d = OWN0;
      last_d  = 1'b0;
    end else if (grant1) begin
      state_d = OWN1;
      last_d  = 1'b1;
    end
  end

`ifdef ONCHIP_ARB_HOLD_EN
  always_comb begin
    hold_d = hold_q;
    if (new_owner)            hold_d = 4'd1;
    else if (granted && hold_q != 4'd15) hold_d = hold_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_q <= 4'd0;
    else          hold_q <= hold_d;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  logic [AW-1:0] sel_address;
  logic [BW-1:0] sel_byteenable;
  logic [DW-1:0] sel_writedata;
  logic          sel_write;
  logic [AW-1:0] address_q;
  logic [BW-1:0] byteenable_q;
  logic [DW-1:0] writedata_q;

  assign sel_address    = grant1 ? m1_address    : m0_address;
  assign sel_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign sel_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign sel_write      = grant1 ? m1_write      : m0_write;

  // Address/data keep the last issued values between accesses to avoid needless toggling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address_q    <= '0;
      byteenable_q <= '0;
      writedata_q  <= '0;
    end else if (granted) begin
      address_q    <= sel_address;
      byteenable_q <= sel_byteenable;
      writedata_q  <= sel_writedata;
    end
  end

  assign mem_chipselect = granted;
  assign mem_write      = granted & sel_write;
  assign mem_address    = granted ? sel_address    : address_q;
  assign mem_byteenable = granted ? sel_byteenable : byteenable_q;
  assign mem_writedata  = granted ? sel_writedata  : writedata_q;

  // Read-return tag: a simultaneous read+write is issued as a write and returns nothing.
  logic rd_pend_q, rd_port_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
    end else begin
      rd_pend_q <= granted & ~sel_write;
      rd_port_q <= grant1;
    end
  end

  assign m0_readdatavalid = rd_pend_q & ~rd_port_q;
  assign m1_readdatavalid = rd_pend_q &  rd_port_q;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed self-checking bench for onchip_mem_arbiter with a behavioural single-port memory.
// Expected grant patterns follow ONCHIP_ARB_HOLD_EN (MAX_HOLD = 4) or strict alternation.
module tb_onchip_mem_arbiter;

`ifdef ONCHIP_ARB_HOLD_EN
  localparam int LIM = 4;
`else
  localparam int LIM = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.AW(14), .DW(32), .MAX_HOLD(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  // Behavioural memory: byte-enabled writes, one-cycle registered read, pre-zeroed.
  logic [31:0] mem_model [0:16383] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem_model[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= mem_model[mem_address];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
    repeat (3) cyc();
    #1;
    checks++; if (mem_chipselect !== 1'b0) begin failures++; $display("FAIL reset_cs got=%b exp=0", mem_chipselect); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", mem_write); end
    checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin failures++; $display("FAIL reset_rdv got=%b exp=00", {m0_readdatavalid, m1_readdatavalid}); end
    checks++; if ({mem_address, mem_byteenable, mem_writedata} !== '0) begin failures++; $display("FAIL reset_mux got=%h/%h/%h exp=0", mem_address, mem_byteenable, mem_writedata); end
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b00) begin failures++; $display("FAIL reset_wait got=%b exp=00", {m0_waitrequest, m1_waitrequest}); end
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    cyc();
    m0_write = 1; m0_address = 14'h0010; m0_writedata = 32'h1234_5678; m0_byteenable = 4'hF;
    #1;
    checks++; if ({mem_chipselect, mem_write, m0_waitrequest} !== 3'b110) begin failures++; $display("FAIL sr_write got=%b exp=110", {mem_chipselect, mem_write, m0_waitrequest}); end
    cyc();
    m0_write = 0; m0_read = 1;
    #1;
    checks++; if ({mem_chipselect, mem_write, m0_waitrequest} !== 3'b100) begin failures++; $display("FAIL sr_issue got=%b exp=100", {mem_chipselect, mem_write, m0_waitrequest}); end
    checks++; if (mem_address !== 14'h0010) begin failures++; $display("FAIL sr_addr got=%h exp=0010", mem_address); end
    cyc();
    m0_read = 0;
    #1;
    checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) begin failures++; $display("FAIL sr_rdv got=%b exp=10", {m0_readdatavalid, m1_readdatavalid}); end
    checks++; if (m0_readdata !== 32'h1234_5678) begin failures++; $display("FAIL sr_data got=%h exp=12345678", m0_readdata); end
    cyc();
    #1;
    checks++; if (m0_readdatavalid !== 1'b0) begin failures++; $display("FAIL sr_rdv_once got=%b exp=0", m0_readdatavalid); end
  endtask

  task automatic test_write_mask();
    cyc();
    m0_write = 1; m0_address = 14'h0005; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'h3;
    #1;
    checks++; if ({mem_byteenable, mem_writedata} !== {4'h3, 32'hDEAD_BEEF}) begin failures++; $display("FAIL wm_bus got=%h/%h exp=3/deadbeef", mem_byteenable, mem_writedata); end
    cyc();
    m0_write = 0; m0_read = 1; m0_byteenable = 4'hF;
    cyc();
    m0_read = 0;
    #1;
    checks++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, 32'h0000_BEEF}) begin failures++; $display("FAIL wm_data got=%b/%h exp=1/0000beef", m0_readdatavalid, m0_readdata); end
    checks++; if ({mem_chipselect, mem_write, mem_address} !== {2'b00, 14'h0005}) begin failures++; $display("FAIL wm_hold got=%b/%b/%h exp=0/0/0005", mem_chipselect, mem_write, mem_address); end
    checks++; if (mem_writedata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wm_hold_data got=%h exp=deadbeef", mem_writedata); end
  endtask

  task automatic test_read_and_write();
    cyc();
    m0_read = 1; m0_write = 1; m0_address = 14'h0006; m0_writedata = 32'h1122_3344;
    #1;
    checks++; if ({mem_chipselect, mem_write} !== 2'b11) begin failures++; $display("FAIL rw_as_write got=%b exp=11", {mem_chipselect, mem_write}); end
    cyc();
    idle_inputs();
    #1;
    checks++; if (m0_readdatavalid !== 1'b0) begin failures++; $display("FAIL rw_no_rdv got=%b exp=0", m0_readdatavalid); end
    m0_read = 1;
    cyc();
    m0_read = 0;
    #1;
    checks++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, 32'h1122_3344}) begin failures++; $display("FAIL rw_data got=%b/%h exp=1/11223344", m0_readdatavalid, m0_readdata); end
  endtask

  task automatic test_contention();
    int exp_port, prev_port, w0, w1;
    logic [31:0] exp_data;
    cyc();
    m0_write = 1; m0_address = 14'h0001; m0_writedata = 32'hAAAA_0001;
    cyc();
    m0_address = 14'h0002; m0_writedata = 32'hBBBB_0002;
    cyc();
    idle_inputs();
    do_reset();
    cyc();
    m0_read = 1; m0_address = 14'h0001;
    m1_read = 1; m1_address = 14'h0002;
    prev_port = 0; w0 = 0; w1 = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      exp_port = (LIM == 4) ? ((i / 4) % 2) : (i % 2);
      checks++; if ({m0_waitrequest, m1_waitrequest} !== (exp_port == 1 ? 2'b10 : 2'b01)) begin failures++; $display("FAIL cont_grant cyc=%0d got=%b exp_port=%0d", i, {m0_waitrequest, m1_waitrequest}, exp_port); end
      checks++; if (mem_address !== (exp_port == 1 ? 14'h0002 : 14'h0001)) begin failures++; $display("FAIL cont_addr cyc=%0d got=%h", i, mem_address); end
      if (i > 0) begin
        exp_data = (prev_port == 1) ? 32'hBBBB_0002 : 32'hAAAA_0001;
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== (prev_port == 1 ? 2'b01 : 2'b10)) begin failures++; $display("FAIL cont_tag cyc=%0d got=%b exp_port=%0d", i, {m0_readdatavalid, m1_readdatavalid}, prev_port); end
        checks++; if (mem_readdata !== exp_data) begin failures++; $display("FAIL cont_data cyc=%0d got=%h exp=%h", i, mem_readdata, exp_data); end
      end
      w0 = m0_waitrequest ? w0 + 1 : 0;
      w1 = m1_waitrequest ? w1 + 1 : 0;
      checks++; if (w0 > LIM || w1 > LIM) begin failures++; $display("FAIL cont_starve cyc=%0d run0=%0d run1=%0d limit=%0d", i, w0, w1, LIM); end
      prev_port = exp_port;
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    cyc();
    m1_read = 1; m1_address = 14'h0003;
    #1;
    checks++; if ({mem_chipselect, m1_waitrequest, mem_address} !== {2'b10, 14'h0003}) begin failures++; $display("FAIL rm_issue got=%b/%b/%h exp=1/0/0003", mem_chipselect, m1_waitrequest, mem_address); end
    #1;
    reset_n = 1'b0;
    m1_read = 0;
    cyc();
    #1;
    checks++; if ({m1_readdatavalid, m0_readdatavalid, mem_chipselect} !== 3'b000) begin failures++; $display("FAIL rm_dropped got=%b exp=000", {m1_readdatavalid, m0_readdatavalid, mem_chipselect}); end
    checks++; if (mem_address !== 14'h0000) begin failures++; $display("FAIL rm_addr_clr got=%h exp=0000", mem_address); end
    cyc();
    reset_n = 1'b1;
    cyc();
    #1;
    checks++; if (m1_readdatavalid !== 1'b0) begin failures++; $display("FAIL rm_no_reissue got=%b exp=0", m1_readdatavalid); end
    m0_read = 1; m0_address = 14'h0001;
    m1_read = 1; m1_address = 14'h0002;
    #1;
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin failures++; $display("FAIL rm_first_win got=%b exp=01", {m0_waitrequest, m1_waitrequest}); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_idle_write();
    cyc();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if ({mem_chipselect, m1_waitrequest} !== 2'b00) begin failures++; $display("FAIL iw_idle cyc=%0d got=%b exp=00", i, {mem_chipselect, m1_waitrequest}); end
      cyc();
    end
    m1_write = 1; m1_address = 14'h0007; m1_writedata = 32'hA5A5_0F0F; m1_byteenable = 4'hF;
    #1;
    checks++; if ({m1_waitrequest, mem_write, mem_address} !== {2'b01, 14'h0007}) begin failures++; $display("FAIL iw_accept got=%b/%b/%h exp=0/1/0007", m1_waitrequest, mem_write, mem_address); end
    checks++; if (mem_writedata !== 32'hA5A5_0F0F) begin failures++; $display("FAIL iw_data got=%h exp=a5a50f0f", mem_writedata); end
    cyc();
    m1_write = 0;
    #1;
    checks++; if ({mem_write, mem_chipselect, m1_readdatavalid} !== 3'b000) begin failures++; $display("FAIL iw_one_cycle got=%b exp=000", {mem_write, mem_chipselect, m1_readdatavalid}); end
    m1_read = 1;
    cyc();
    m1_read = 0;
    #1;
    checks++; if ({m1_readdatavalid, m1_readdata} !== {1'b1, 32'hA5A5_0F0F}) begin failures++; $display("FAIL iw_readback got=%b/%h exp=1/a5a50f0f", m1_readdatavalid, m1_readdata); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_mask();
    test_read_and_write();
    test_contention();
    test_reset_mid();
    test_idle_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
